// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding, bus constants and address-match helper.
// Used by the target (i2c_target) and the existing bus master.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADDR     = 3'd1,
        ADDR_ACK = 3'd2,
        WR_DATA  = 3'd3,
        WR_ACK   = 3'd4,
        RD_DATA  = 3'd5,
        RD_ACK   = 3'd6,
        IGNORE   = 3'd7
    } i2c_state_e;

    localparam logic [6:0] GCALL_ADDR = 7'h00;
    localparam logic       ACK        = 1'b0;
    localparam logic       NACK       = 1'b1;

    // Address byte hits own address (either R/W), or general call write when enabled.
    function automatic logic addr_hit(input logic [7:0] addr_byte,
                                      input logic [6:0] own_addr,
                                      input logic       gcall_en);
        return (addr_byte[7:1] == own_addr) |
               (gcall_en & (addr_byte[7:1] == GCALL_ADDR) & (addr_byte[0] == 1'b0));
    endfunction

endpackage

// File: rtl/i2c_sync_edge.sv
// Multi-flop synchronizer for one bus line plus registered rise/fall detect.
// level, rise and fall are mutually aligned, SYNC_STAGES+1 clk after the pin.
module i2c_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;

    // Shift the pin into the chain and compare last stage with the held level.
    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], din};
        level_d = sync_q[SYNC_STAGES-1];
        rise_d  = sync_q[SYNC_STAGES-1] & ~level_q;
        fall_d  = ~sync_q[SYNC_STAGES-1] & level_q;
    end

    // Synchronizer and edge registers; reset to the idle-high bus level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= {SYNC_STAGES{1'b1}};
            level_q <= 1'b1;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/i2c_target.sv
// I2C target: START/STOP decode, 7-bit address match, byte write/read to a host port.
// Define I2C_TARGET_GCALL_EN to also ACK the general call address (7'h00, write only).
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] TARGET_ADDR = 7'h77,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    inout  wire        sda,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       rd_nack,
    output logic       stop_det,
    output logic [2:0] state
);

`ifdef I2C_TARGET_GCALL_EN
    localparam logic GCALL_EN = 1'b1;
`else
    localparam logic GCALL_EN = 1'b0;
`endif

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;
    logic start_seen, stop_seen;
    logic [7:0] byte_in;

    i2c_state_e state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] shift_q, shift_d;
    logic       rw_q, rw_d;
    logic       sda_oe_q, sda_oe_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       tx_req_q, tx_req_d;
    logic       rd_nack_q, rd_nack_d;
    logic       stop_det_q, stop_det_d;

    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
        .clk(clk), .rst(rst), .din(sclk),
        .level(scl_lvl), .rise(scl_rise), .fall(scl_fall)
    );

    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
        .clk(clk), .rst(rst), .din(sda),
        .level(sda_lvl), .rise(sda_rise), .fall(sda_fall)
    );

    assign start_seen = sda_fall & scl_lvl;
    assign stop_seen  = sda_rise & scl_lvl;

    // Next-state logic: bus conditions first (STOP beats START), then per-state bit handling.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        rw_d       = rw_q;
        sda_oe_d   = sda_oe_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_req_d   = 1'b0;
        rd_nack_d  = 1'b0;
        stop_det_d = 1'b0;
        byte_in    = {shift_q, sda_lvl};

        if (stop_seen) begin
            state_d    = IDLE;
            sda_oe_d   = 1'b0;
            bit_cnt_d  = 4'd0;
            stop_det_d = 1'b1;
        end else if (start_seen) begin
            state_d   = ADDR;
            sda_oe_d  = 1'b0;
            bit_cnt_d = 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    sda_oe_d = 1'b0;
                end
                ADDR: begin
                    if (scl_rise) begin
                        shift_d = byte_in[6:0];
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = 4'd8;
                            rw_d      = byte_in[0];
                            if (addr_hit(byte_in, TARGET_ADDR, GCALL_EN)) begin
                                state_d = ADDR_ACK;
                            end else begin
                                state_d = IGNORE;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end else begin
                        shift_d = shift_q;
                    end
                end
                // ACK slots: bit_cnt 8 = before the ACK rise, 0 = after it.
                ADDR_ACK, WR_ACK: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            sda_oe_d = 1'b0;
                            if ((state_q == ADDR_ACK) && rw_q) begin
                                state_d  = RD_DATA;
                                tx_req_d = 1'b1;
                            end else begin
                                state_d = WR_DATA;
                            end
                        end
                    end else if (scl_rise) begin
                        bit_cnt_d = 4'd0;
                    end else begin
                        bit_cnt_d = bit_cnt_q;
                    end
                end
                WR_DATA: begin
                    if (scl_rise) begin
                        shift_d = byte_in[6:0];
                        if (bit_cnt_q == 4'd7) begin
                            rx_data_d  = byte_in;
                            rx_valid_d = 1'b1;
                            bit_cnt_d  = 4'd8;
                            state_d    = WR_ACK;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end else begin
                        shift_d = shift_q;
                    end
                end
                // tx_data is captured only in the tx_req cycle; MSB goes out immediately.
                RD_DATA: begin
                    if (tx_req_q) begin
                        shift_d   = tx_data[6:0];
                        sda_oe_d  = ~tx_data[7];
                        bit_cnt_d = 4'd0;
                    end else if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_oe_d = 1'b0;
                            state_d  = RD_ACK;
                        end else begin
                            shift_d  = {shift_q[5:0], 1'b0};
                            sda_oe_d = ~shift_q[6];
                        end
                    end else begin
                        shift_d = shift_q;
                    end
                end
                RD_ACK: begin
                    sda_oe_d = 1'b0;
                    if (scl_rise) begin
                        if (sda_lvl == NACK) begin
                            rd_nack_d = 1'b1;
                            state_d   = IGNORE;
                        end else begin
                            bit_cnt_d = 4'd0;
                        end
                    end else if (scl_fall && (bit_cnt_q == 4'd0)) begin
                        tx_req_d = 1'b1;
                        state_d  = RD_DATA;
                    end else begin
                        bit_cnt_d = bit_cnt_q;
                    end
                end
                IGNORE: begin
                    sda_oe_d = 1'b0;
                end
                default: begin
                    state_d  = IDLE;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= 4'd0;
            shift_q    <= 7'd0;
            rw_q       <= 1'b0;
            sda_oe_q   <= 1'b0;
            rx_data_q  <= 8'd0;
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
            rd_nack_q  <= 1'b0;
            stop_det_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            rw_q       <= rw_d;
            sda_oe_q   <= sda_oe_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_req_q   <= tx_req_d;
            rd_nack_q  <= rd_nack_d;
            stop_det_q <= stop_det_d;
        end
    end

    assign sda      = sda_oe_q ? 1'b0 : 1'bz;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign tx_req   = tx_req_q;
    assign rd_nack  = rd_nack_q;
    assign stop_det = stop_det_q;
    assign state    = state_q;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: table of write transactions plus hand-written read,
// ignore/repeated-START and mid-ACK reset sequences, driven by a bit-banged master.
module tb_i2c_target;

    localparam int         Q        = 6;
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_IGNORE = 3'd7;

    logic       clk = 1'b0;
    logic       rst;
    logic       m_scl;
    logic       m_sda_low;
    wire        sda_w;
    logic [7:0] rx_data;
    logic [7:0] tx_data;
    logic [7:0] tx_byte;
    logic       rx_valid, tx_req, rd_nack, stop_det;
    logic [2:0] state;

    int n_cmp = 0;
    int n_err = 0;
    int rxv_cnt = 0, txr_cnt = 0, nack_cnt = 0, stop_cnt = 0;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        logic       exp_aack;
        logic       exp_dack;
        int         exp_rxv;
        logic [7:0] exp_rx;
    } wvec_t;

    wvec_t vec [7];

    always #5 clk = ~clk;

    assign sda_w = m_sda_low ? 1'b0 : 1'bz;
    pullup (sda_w);

    i2c_target #(.TARGET_ADDR(7'h77), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .sclk(m_scl), .sda(sda_w),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data),
        .tx_req(tx_req), .rd_nack(rd_nack), .stop_det(stop_det), .state(state)
    );

    // Pulse counters; tx_data only carries the wanted byte in the tx_req cycle.
    always @(negedge clk) begin
        if (rx_valid) rxv_cnt++;
        if (tx_req)   txr_cnt++;
        if (rd_nack)  nack_cnt++;
        if (stop_det) stop_cnt++;
        tx_data = tx_req ? tx_byte : 8'hC3;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic wait_q();
        repeat (Q) @(posedge clk);
        #1;
    endtask

    task automatic bus_start();
        m_sda_low = 1'b1; wait_q();
        m_scl = 1'b0;     wait_q();
    endtask

    task automatic bus_rstart();
        m_sda_low = 1'b0; wait_q();
        m_scl = 1'b1;     wait_q();
        m_sda_low = 1'b1; wait_q();
        m_scl = 1'b0;     wait_q();
    endtask

    task automatic bus_stop();
        m_sda_low = 1'b1; wait_q();
        m_scl = 1'b1;     wait_q();
        m_sda_low = 1'b0; wait_q();
        wait_q();
    endtask

    task automatic bus_bit(input logic b, output logic r);
        m_sda_low = ~b; wait_q();
        m_scl = 1'b1;   wait_q();
        r = sda_w;      wait_q();
        m_scl = 1'b0;   wait_q();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bus_bit(b[i], r);
        bus_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] b);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, r);
            b[i] = r;
        end
        bus_bit(mack, r);
    endtask

    initial begin
        logic       a, d, r;
        logic [7:0] b;
        int         rxv0, txr0, nack0, stop0;

        vec[0] = '{8'hEE, 8'hA5, 1'b0, 1'b0, 1, 8'hA5};
        vec[1] = '{8'hEE, 8'h00, 1'b0, 1'b0, 1, 8'h00};
        vec[2] = '{8'hEE, 8'hFF, 1'b0, 1'b0, 1, 8'hFF};
        vec[3] = '{8'h42, 8'h55, 1'b1, 1'b1, 0, 8'hFF};
        vec[4] = '{8'h76, 8'h12, 1'b1, 1'b1, 0, 8'hFF};
`ifdef I2C_TARGET_GCALL_EN
        vec[5] = '{8'h00, 8'h55, 1'b0, 1'b0, 1, 8'h55};
`else
        vec[5] = '{8'h00, 8'h55, 1'b1, 1'b1, 0, 8'hFF};
`endif
        vec[6] = '{8'hEE, 8'h3C, 1'b0, 1'b0, 1, 8'h3C};

        rst = 1'b1; m_scl = 1'b1; m_sda_low = 1'b0; tx_byte = 8'h3C;
        repeat (5) @(posedge clk);
        #1;
        chk("reset_sda", sda_w, 1'b1);
        chk("reset_rx_data", rx_data, 8'h00);
        chk("reset_rx_valid", rx_valid, 1'b0);
        chk("reset_tx_req", tx_req, 1'b0);
        chk("reset_rd_nack", rd_nack, 1'b0);
        chk("reset_stop_det", stop_det, 1'b0);
        chk("reset_state", state, S_IDLE);
        rst = 1'b0;
        wait_q();

        for (int i = 0; i < 7; i++) begin
            rxv0 = rxv_cnt; stop0 = stop_cnt;
            bus_start();
            write_byte(vec[i].addr, a);
            write_byte(vec[i].data, d);
            bus_stop();
            chk($sformatf("row%0d_addr_ack", i), a, vec[i].exp_aack);
            chk($sformatf("row%0d_data_ack", i), d, vec[i].exp_dack);
            chk($sformatf("row%0d_rx_valid_cnt", i), rxv_cnt - rxv0, vec[i].exp_rxv);
            chk($sformatf("row%0d_rx_data", i), rx_data, vec[i].exp_rx);
            chk($sformatf("row%0d_stop_det_cnt", i), stop_cnt - stop0, 1);
            chk($sformatf("row%0d_state", i), state, S_IDLE);
        end

        // Read: ACK the first byte, NACK the second.
        rxv0 = rxv_cnt; txr0 = txr_cnt; nack0 = nack_cnt; stop0 = stop_cnt;
        bus_start();
        write_byte(8'hEF, a);
        chk("rd_addr_ack", a, 1'b0);
        chk("rd_tx_req_first", txr_cnt - txr0, 1);
        read_byte(1'b0, b);
        chk("rd_byte0", b, 8'h3C);
        chk("rd_tx_req_second", txr_cnt - txr0, 2);
        chk("rd_nack_none_yet", nack_cnt - nack0, 0);
        read_byte(1'b1, b);
        chk("rd_byte1", b, 8'h3C);
        chk("rd_nack_cnt", nack_cnt - nack0, 1);
        chk("rd_tx_req_total", txr_cnt - txr0, 2);
        chk("rd_state_ignore", state, S_IGNORE);
        bus_stop();
        chk("rd_stop_det_cnt", stop_cnt - stop0, 1);
        chk("rd_no_rx_valid", rxv_cnt - rxv0, 0);

        // Foreign address, then repeated START with a partial byte, then a real write.
        rxv0 = rxv_cnt; txr0 = txr_cnt;
        bus_start();
        write_byte(8'h42, a);
        chk("ign_addr_nack", a, 1'b1);
        write_byte(8'h00, d);
        chk("ign_data_nack", d, 1'b1);
        chk("ign_state", state, S_IGNORE);
        chk("ign_no_rx_valid", rxv_cnt - rxv0, 0);
        chk("ign_no_tx_req", txr_cnt - txr0, 0);
        bus_rstart();
        write_byte(8'hEE, a);
        chk("rs_addr_ack0", a, 1'b0);
        bus_bit(1'b1, r); bus_bit(1'b0, r); bus_bit(1'b1, r); bus_bit(1'b0, r);
        bus_rstart();
        write_byte(8'hEE, a);
        chk("rs_addr_ack1", a, 1'b0);
        write_byte(8'h01, d);
        chk("rs_data_ack", d, 1'b0);
        chk("rs_rx_valid_cnt", rxv_cnt - rxv0, 1);
        chk("rs_rx_data", rx_data, 8'h01);
        bus_stop();

        // Reset while the target holds SDA low in a write ACK slot.
        bus_start();
        write_byte(8'hEE, a);
        for (int i = 7; i >= 0; i--) begin
            b = 8'h81;
            bus_bit(b[i], r);
        end
        chk("rst_ack_driven", sda_w, 1'b0);
        chk("rst_rx_before", rx_data, 8'h81);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_sda_released", sda_w, 1'b1);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_rx_valid", rx_valid, 1'b0);
        chk("rst_tx_req", tx_req, 1'b0);
        chk("rst_rd_nack", rd_nack, 1'b0);
        chk("rst_stop_det", stop_det, 1'b0);
        chk("rst_state", state, S_IDLE);
        rst = 1'b0;
        m_sda_low = 1'b0;
        wait_q();
        m_scl = 1'b1;
        wait_q();
        chk("rst_state_after", state, S_IDLE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
